// File: rtl/neuron_pkg.sv
// Shared state type and arithmetic helpers for the STDP leaky integrate-and-fire neuron.
// Pure package; no timing.
package neuron_pkg;

    typedef enum logic {
        INTEGRATE  = 1'b0,
        REFRACTORY = 1'b1
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    function automatic int trace_max(input int bits);
        return (1 << bits) - 1;
    endfunction

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] max);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, max}) ? max : s[31:0];
    endfunction

    function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : 32'd0;
    endfunction

endpackage

// File: rtl/stdp_synapse.sv
// One synapse: weight register plus presynaptic trace, updated by pair-based STDP.
// Updates on the enabled edge (1-cycle latency); en low holds weight and trace.
module stdp_synapse
    import neuron_pkg::*;
#(
    parameter int W_BITS     = 4,
    parameter int TRACE_BITS = 3,
    parameter int W_INIT     = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              learn,
    input  logic              in_spike_i,
    input  logic              fire_i,
    input  logic              post_trace_nz_i,
    output logic [W_BITS-1:0] weight_o
);
    localparam int TMAX = trace_max(TRACE_BITS);
    localparam int WMAX = trace_max(W_BITS);

    logic [W_BITS-1:0]     w_q, w_d;
    logic [TRACE_BITS-1:0] pre_q, pre_d;

    // Learning looks at the trace value from before this edge, so a spike on the
    // current edge counts through in_spike_i rather than through pre_q.
    always_comb begin
        w_d   = w_q;
        pre_d = pre_q;
        if (en) begin
            pre_d = in_spike_i ? TRACE_BITS'(TMAX)
                               : TRACE_BITS'(sat_sub(32'(pre_q), 32'd1));
            if (learn) begin
                if (fire_i && (pre_q != '0 || in_spike_i))
                    w_d = W_BITS'(sat_add(32'(w_q), 32'd1, 32'(WMAX)));
                else if (!fire_i && in_spike_i && post_trace_nz_i)
                    w_d = W_BITS'(sat_sub(32'(w_q), 32'd1));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w_q   <= W_BITS'(W_INIT);
            pre_q <= '0;
        end else begin
            w_q   <= w_d;
            pre_q <= pre_d;
        end
    end

    assign weight_o = w_q;

endmodule

// File: rtl/stdp_lif_neuron.sv
// Leaky integrate-and-fire soma with N_IN STDP synapses and a refractory period.
// Inputs at edge k show as spike_out in the following cycle; en low holds all state.
module stdp_lif_neuron
    import neuron_pkg::*;
#(
    parameter int N_IN       = 8,
    parameter int W_BITS     = 4,
    parameter int V_BITS     = 8,
    parameter int THRESH     = 64,
    parameter int LEAK_SHIFT = 3,
    parameter int REFRAC     = 3,
    parameter int TRACE_BITS = 3,
    parameter int W_INIT     = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     learn,
    input  logic [N_IN-1:0]          inputs,
    output logic                     spike_out,
    output logic [V_BITS-1:0]        membrane,
    output logic [N_IN*W_BITS-1:0]   weights
);
    localparam int SUM_BITS = W_BITS + clog2(N_IN);
    localparam int ACC_BITS = ((V_BITS > SUM_BITS) ? V_BITS : SUM_BITS) + 1;
    localparam int CNT_BITS = (clog2(REFRAC + 1) > 0) ? clog2(REFRAC + 1) : 1;
    localparam int TMAX     = trace_max(TRACE_BITS);
    localparam logic [ACC_BITS-1:0] V_MAX = ACC_BITS'((1 << V_BITS) - 1);

    state_e                state_q, state_d;
    logic [V_BITS-1:0]     v_q, v_d;
    logic                  spike_q, spike_d;
    logic [CNT_BITS-1:0]   cnt_q, cnt_d;
    logic [TRACE_BITS-1:0] post_q, post_d;

    logic [W_BITS-1:0]     w_arr [N_IN];
    logic [SUM_BITS-1:0]   sum;
    logic [ACC_BITS-1:0]   acc;
    logic [V_BITS-1:0]     v_next;
    logic                  fire;
    logic                  post_nz;

    always_comb begin
        sum = '0;
        for (int i = 0; i < N_IN; i++)
            if (inputs[i]) sum = sum + SUM_BITS'(w_arr[i]);
    end

    // v - (v >> LEAK_SHIFT) never underflows, so only the top needs clamping.
    always_comb begin
        acc    = ACC_BITS'(v_q) - ACC_BITS'(v_q >> LEAK_SHIFT) + ACC_BITS'(sum);
        v_next = (acc > V_MAX) ? V_BITS'(V_MAX) : V_BITS'(acc);
    end

    assign fire    = en && (state_q == INTEGRATE) && (v_next >= V_BITS'(THRESH));
    assign post_nz = (post_q != '0);

    always_comb begin
        state_d = state_q;
        v_d     = v_q;
        cnt_d   = cnt_q;
        post_d  = post_q;
        spike_d = 1'b0;
        if (en) begin
            post_d = fire ? TRACE_BITS'(TMAX) : TRACE_BITS'(sat_sub(32'(post_q), 32'd1));
            case (state_q)
                INTEGRATE: begin
                    if (fire) begin
                        spike_d = 1'b1;
                        v_d     = '0;
                        cnt_d   = CNT_BITS'(REFRAC);
                        state_d = (REFRAC > 0) ? REFRACTORY : INTEGRATE;
                    end else begin
                        v_d = v_next;
                    end
                end
                REFRACTORY: begin
                    v_d   = '0;
                    cnt_d = cnt_q - CNT_BITS'(1);
                    if (cnt_q <= CNT_BITS'(1)) begin
                        cnt_d   = '0;
                        state_d = INTEGRATE;
                    end
                end
                default: state_d = INTEGRATE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INTEGRATE;
            v_q     <= '0;
            spike_q <= 1'b0;
            cnt_q   <= '0;
            post_q  <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            spike_q <= spike_d;
            cnt_q   <= cnt_d;
            post_q  <= post_d;
        end
    end

    for (genvar g = 0; g < N_IN; g++) begin : g_syn
        stdp_synapse #(
            .W_BITS     (W_BITS),
            .TRACE_BITS (TRACE_BITS),
            .W_INIT     (W_INIT)
        ) u_syn (
            .clk             (clk),
            .rst_n           (rst_n),
            .en              (en),
            .learn           (learn),
            .in_spike_i      (inputs[g]),
            .fire_i          (fire),
            .post_trace_nz_i (post_nz),
            .weight_o        (w_arr[g])
        );
        assign weights[g*W_BITS +: W_BITS] = w_arr[g];
    end

    assign spike_out = spike_q;
    assign membrane  = v_q;

endmodule

// File: tb/tb_stdp_lif_neuron.sv
// Directed bench for stdp_lif_neuron with an integer-level neuron model checked every cycle.
module tb_stdp_lif_neuron;
    localparam int N      = 8;
    localparam int WMAX   = 15;
    localparam int TMAX   = 7;
    localparam int THRESH = 64;
    localparam int REFRAC = 3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        learn;
    logic [7:0]  inputs;
    logic        spike_out;
    logic [7:0]  membrane;
    logic [31:0] weights;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    int m_w   [N];
    int m_pre [N];
    int m_post;
    int m_v;
    int m_ref;
    bit m_spike;

    stdp_lif_neuron #(
        .N_IN(8), .W_BITS(4), .V_BITS(8), .THRESH(64), .LEAK_SHIFT(3),
        .REFRAC(3), .TRACE_BITS(3), .W_INIT(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .learn     (learn),
        .inputs    (inputs),
        .spike_out (spike_out),
        .membrane  (membrane),
        .weights   (weights)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_weights();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*4 +: 4] = 4'(m_w[i]);
        return r;
    endfunction

    task automatic model_reset();
        m_spike = 1'b0;
        m_v     = 0;
        m_ref   = 0;
        m_post  = 0;
        for (int i = 0; i < N; i++) begin
            m_w[i]   = 4;
            m_pre[i] = 0;
        end
    endtask

    task automatic model_step(input logic e, input logic l, input logic [7:0] x);
        int s;
        int vn;
        bit f;
        if (!e) begin
            m_spike = 1'b0;
            return;
        end
        s = 0;
        for (int i = 0; i < N; i++) if (x[i]) s += m_w[i];
        f = 1'b0;
        if (m_ref > 0) begin
            m_ref--;
            m_v = 0;
        end else begin
            vn = m_v - m_v / 8 + s;
            if (vn > 255) vn = 255;
            if (vn >= THRESH) begin
                f     = 1'b1;
                m_v   = 0;
                m_ref = REFRAC;
            end else begin
                m_v = vn;
            end
        end
        m_spike = f;
        if (l) begin
            for (int i = 0; i < N; i++) begin
                if (f && (m_pre[i] > 0 || x[i]))
                    m_w[i] = (m_w[i] < WMAX) ? m_w[i] + 1 : WMAX;
                else if (!f && x[i] && m_post > 0)
                    m_w[i] = (m_w[i] > 0) ? m_w[i] - 1 : 0;
            end
        end
        for (int i = 0; i < N; i++) m_pre[i] = x[i] ? TMAX : ((m_pre[i] > 0) ? m_pre[i] - 1 : 0);
        m_post = f ? TMAX : ((m_post > 0) ? m_post - 1 : 0);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("spike", {31'b0, spike_out}, {31'b0, m_spike});
            check("membrane", {24'b0, membrane}, 32'(m_v));
            check("weights", weights, model_weights());
        end
    end

    task automatic tick(input logic e, input logic l, input logic [7:0] x);
        en     = e;
        learn  = l;
        inputs = x;
        @(posedge clk);
        model_step(e, l, x);
        @(negedge clk);
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        en     = 1'b0;
        inputs = '0;
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int nsp;
        int n;
        rst_n  = 1'b0;
        en     = 1'b0;
        learn  = 1'b0;
        inputs = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_spike", {31'b0, spike_out}, 32'd0);
        check("rst_membrane", {24'b0, membrane}, 32'd0);
        check("rst_weights", weights, 32'h4444_4444);
        rst_n  = 1'b1;
        chk_en = 1'b1;

        repeat (10) tick(1'b0, 1'b0, 8'hFF);
        check("hold_membrane", {24'b0, membrane}, 32'd0);

        tick(1'b1, 1'b0, 8'hFF);
        check("int_edge1", {24'b0, membrane}, 32'd32);
        tick(1'b1, 1'b0, 8'hFF);
        check("int_edge2", {24'b0, membrane}, 32'd60);
        tick(1'b0, 1'b0, 8'hFF);
        check("int_hold", {24'b0, membrane}, 32'd60);
        tick(1'b1, 1'b0, 8'hFF);
        check("fire_spike", {31'b0, spike_out}, 32'd1);
        check("fire_membrane", {24'b0, membrane}, 32'd0);
        repeat (3) tick(1'b1, 1'b0, 8'hFF);
        check("refrac_membrane", {24'b0, membrane}, 32'd0);
        tick(1'b1, 1'b0, 8'hFF);
        check("resume_edge1", {24'b0, membrane}, 32'd32);
        tick(1'b1, 1'b0, 8'hFF);
        tick(1'b1, 1'b0, 8'hFF);
        check("refire_spike", {31'b0, spike_out}, 32'd1);

        do_reset();
        nsp = 0;
        repeat (100) begin
            tick(1'b1, 1'b0, 8'h01);
            if (spike_out) nsp++;
        end
        check("leak_spikes", 32'(nsp), 32'd0);
        check("leak_equilibrium", {24'b0, membrane}, 32'd32);

        do_reset();
        repeat (3) tick(1'b1, 1'b1, 8'hFF);
        check("ltp_spike", {31'b0, spike_out}, 32'd1);
        check("ltp_weights", weights, 32'h5555_5555);
        repeat (2) tick(1'b1, 1'b1, 8'h00);
        tick(1'b1, 1'b1, 8'h04);
        check("ltd_weights", weights, 32'h5555_5455);

        // Quiet gaps let the post trace drain so each burst only sees LTP.
        for (int k = 0; k < 20; k++) begin
            repeat (7) tick(1'b1, 1'b1, 8'h00);
            n = 0;
            do begin
                tick(1'b1, 1'b1, 8'hFF);
                n++;
            end while (!m_spike && n < 12);
            check("sat_burst_fire", {31'b0, spike_out}, 32'd1);
        end
        check("sat_weights", weights, 32'hFFFF_FFFF);

        chk_en = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_spike", {31'b0, spike_out}, 32'd0);
        check("arst_membrane", {24'b0, membrane}, 32'd0);
        check("arst_weights", weights, 32'h4444_4444);
        model_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        tick(1'b1, 1'b0, 8'hFF);
        check("arst_refrac_cleared", {24'b0, membrane}, 32'd32);

        repeat (30) tick(1'b1, 1'b1, 8'hFF);

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
